// File: rtl/temporizador_multicanal.sv
// Multi-channel frame timer: each flag is high for the first ciclos_i cycles of a PERIODO-cycle frame.
// Latency: rising edge of enter seen at clock edge E -> frame cycle 0 (flags/busy valid) in the cycle after E.
// Backpressure: none; stop aborts a running frame at the next edge, a new enter edge restarts the frame.
module temporizador_multicanal #(
    parameter int N_CH    = 3,
    parameter int W       = 5,
    parameter int PERIODO = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enter,
    input  logic              stop,
    input  logic              modo,
    input  logic [N_CH*W-1:0] ciclos,
    output logic [N_CH-1:0]   flags,
    output logic              busy,
    output logic              done
);

    // Frame counter width; a one-bit floor keeps the vector legal for tiny frames.
    localparam int CW = (PERIODO > 1) ? $clog2(PERIODO) : 1;
    // Common width for counter-vs-threshold compares, one bit wider than either operand.
    localparam int CMPW = ((CW > W) ? CW : W) + 1;
    localparam logic [CW-1:0] ULTIMO = CW'(PERIODO - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } estado_t;

    estado_t           estado;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_sig;
    logic [N_CH*W-1:0] ciclos_l;
    logic              modo_l;
    logic              enter_q;
    logic              inicio;

    // A start is only the 0->1 transition of enter; holding it high does nothing more.
    assign inicio  = enter & ~enter_q;
    assign cnt_sig = cnt + 1'b1;

    // Flag pattern for frame cycle k: channel i is high while k is below its threshold.
    // Thresholds at or above PERIODO simply keep the flag high all frame (no wrap).
    function automatic logic [N_CH-1:0] calc_flags(input logic [CW-1:0]     k,
                                                   input logic [N_CH*W-1:0] c);
        logic [N_CH-1:0] f;
        f = '0;
        for (int i = 0; i < N_CH; i++) begin
            f[i] = (CMPW'(k) < CMPW'(c[i*W +: W]));
        end
        return f;
    endfunction

    // Edge-history register for enter; cleared by reset so a held enter restarts after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enter_q <= 1'b0;
        end else begin
            enter_q <= enter;
        end
    end

    // Frame FSM; outputs are computed from the next frame cycle so they are registered for it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado   <= IDLE;
            cnt      <= '0;
            ciclos_l <= '0;
            modo_l   <= 1'b0;
            flags    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            if ((estado == RUN) && stop) begin
                // Abort wins over a simultaneous start.
                estado <= IDLE;
                cnt    <= '0;
                flags  <= '0;
                busy   <= 1'b0;
                done   <= 1'b0;
            end else if (inicio) begin
                // Fresh start or restart: new frame with newly captured settings.
                estado   <= RUN;
                cnt      <= '0;
                ciclos_l <= ciclos;
                modo_l   <= modo;
                flags    <= calc_flags('0, ciclos);
                busy     <= 1'b1;
                done     <= (ULTIMO == '0);
            end else if (estado == RUN) begin
                if (cnt == ULTIMO) begin
                    if (modo_l) begin
                        // Periodic: back-to-back frame, settings re-captured at the boundary.
                        cnt      <= '0;
                        ciclos_l <= ciclos;
                        modo_l   <= modo;
                        flags    <= calc_flags('0, ciclos);
                        busy     <= 1'b1;
                        done     <= (ULTIMO == '0);
                    end else begin
                        // One-shot: the frame is over.
                        estado <= IDLE;
                        cnt    <= '0;
                        flags  <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b0;
                    end
                end else begin
                    cnt   <= cnt_sig;
                    flags <= calc_flags(cnt_sig, ciclos_l);
                    busy  <= 1'b1;
                    done  <= (cnt_sig == ULTIMO);
                end
            end else begin
                cnt   <= '0;
                flags <= '0;
                busy  <= 1'b0;
                done  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_temporizador_multicanal.sv
// Bench for temporizador_multicanal: two instances (PERIODO 32 and 20) checked every cycle
// against a frame-level model, plus hand-computed per-scenario cycle counts.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_temporizador_multicanal;

    localparam int N_CH = 3;
    localparam int W    = 5;

    logic              clk;
    logic              rst_n;
    logic              enter;
    logic              stop;
    logic              modo;
    logic [N_CH*W-1:0] ciclos;
    logic [N_CH-1:0]   flags32, flags20;
    logic              busy32, busy20, done32, done20;

    int checks = 0;
    int errors = 0;

    temporizador_multicanal #(.N_CH(N_CH), .W(W), .PERIODO(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .enter(enter), .stop(stop), .modo(modo),
        .ciclos(ciclos), .flags(flags32), .busy(busy32), .done(done32)
    );

    temporizador_multicanal #(.N_CH(N_CH), .W(W), .PERIODO(20)) dut20 (
        .clk(clk), .rst_n(rst_n), .enter(enter), .stop(stop), .modo(modo),
        .ciclos(ciclos), .flags(flags20), .busy(busy20), .done(done20)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int per(input int j);
        return (j == 0) ? 32 : 20;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Frame-level model: for each instance, whether a frame is running, which cycle of it,
    // and the thresholds/mode captured at its start.
    bit m_run [2];
    int m_k   [2];
    int m_cic [2][N_CH];
    bit m_modo[2];
    bit m_prev;
    bit m_start;

    task automatic capture(input int j);
        m_modo[j] = modo;
        for (int i = 0; i < N_CH; i++) m_cic[j][i] = int'(ciclos[i*W +: W]);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev = 1'b0;
            for (int j = 0; j < 2; j++) begin
                m_run[j]  = 1'b0;
                m_k[j]    = 0;
                m_modo[j] = 1'b0;
                for (int i = 0; i < N_CH; i++) m_cic[j][i] = 0;
            end
        end else begin
            m_start = enter && !m_prev;
            m_prev  = enter;
            for (int j = 0; j < 2; j++) begin
                if (m_run[j] && stop) begin
                    m_run[j] = 1'b0;
                end else if (m_start) begin
                    m_run[j] = 1'b1;
                    m_k[j]   = 0;
                    capture(j);
                end else if (m_run[j]) begin
                    if (m_k[j] == per(j) - 1) begin
                        if (m_modo[j]) begin
                            m_k[j] = 0;
                            capture(j);
                        end else begin
                            m_run[j] = 1'b0;
                        end
                    end else begin
                        m_k[j] = m_k[j] + 1;
                    end
                end
            end
        end
    end

    // Per-scenario tallies of DUT output activity.
    int cb[2];
    int cd[2];
    int cf[2][N_CH];

    task automatic clear_counts();
        for (int j = 0; j < 2; j++) begin
            cb[j] = 0;
            cd[j] = 0;
            for (int i = 0; i < N_CH; i++) cf[j][i] = 0;
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int j = 0; j < 2; j++) begin
                logic [N_CH-1:0] ef;
                logic [N_CH-1:0] af;
                logic            ab, ad, eb, ed;
                for (int i = 0; i < N_CH; i++) ef[i] = m_run[j] && (m_k[j] < m_cic[j][i]);
                eb = m_run[j];
                ed = m_run[j] && (m_k[j] == per(j) - 1);
                af = (j == 0) ? flags32 : flags20;
                ab = (j == 0) ? busy32  : busy20;
                ad = (j == 0) ? done32  : done20;
                chk($sformatf("cycle_p%0d_t%0t {flags,busy,done}", per(j), $time),
                    int'({af, ab, ad}), int'({ef, eb, ed}));
                if (ab) cb[j]++;
                if (ad) cd[j]++;
                for (int i = 0; i < N_CH; i++) if (af[i]) cf[j][i]++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_counts(input string nm, input int j, input int b, input int d,
                                 input int f0, input int f1, input int f2);
        chk($sformatf("%s_p%0d_busy_cycles", nm, per(j)), cb[j], b);
        chk($sformatf("%s_p%0d_done_pulses", nm, per(j)), cd[j], d);
        chk($sformatf("%s_p%0d_flag0_cycles", nm, per(j)), cf[j][0], f0);
        chk($sformatf("%s_p%0d_flag1_cycles", nm, per(j)), cf[j][1], f1);
        chk($sformatf("%s_p%0d_flag2_cycles", nm, per(j)), cf[j][2], f2);
    endtask

    task automatic expect_zero_outputs(input string nm);
        chk({nm, "_flags32"}, int'(flags32), 0);
        chk({nm, "_busy32"},  int'(busy32),  0);
        chk({nm, "_done32"},  int'(done32),  0);
        chk({nm, "_flags20"}, int'(flags20), 0);
        chk({nm, "_busy20"},  int'(busy20),  0);
        chk({nm, "_done20"},  int'(done20),  0);
    endtask

    initial begin
        rst_n  = 1'b0;
        enter  = 1'b0;
        stop   = 1'b0;
        modo   = 1'b0;
        ciclos = {5'd15, 5'd10, 5'd5};
        clear_counts();
        #3;
        expect_zero_outputs("reset");
        #14;
        rst_n = 1'b1;
        tick(2);

        // One-shot frame, enter held 10 cycles: single frame only.
        clear_counts();
        modo   = 1'b0;
        ciclos = {5'd15, 5'd10, 5'd5};
        enter  = 1'b1;
        tick(10);
        enter = 1'b0;
        tick(35);
        expect_counts("oneshot", 0, 32, 1, 5, 10, 15);
        expect_counts("oneshot", 1, 20, 1, 5, 10, 15);

        // Periodic, thresholds changed during frame 1, stop during frame 2.
        clear_counts();
        modo  = 1'b1;
        enter = 1'b1;
        tick(1);
        enter = 1'b0;
        tick(4);
        ciclos = {5'd1, 5'd2, 5'd3};
        tick(37);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        modo = 1'b0;
        tick(5);
        expect_counts("periodic", 0, 42, 1, 8, 12, 16);
        expect_counts("periodic", 1, 42, 2, 10, 14, 17);

        // Saturated and zero thresholds.
        clear_counts();
        ciclos = {5'd31, 5'd0, 5'd31};
        enter  = 1'b1;
        tick(1);
        enter = 1'b0;
        tick(36);
        expect_counts("saturate", 0, 32, 1, 31, 0, 31);
        expect_counts("saturate", 1, 20, 1, 20, 0, 20);

        // Restart by a second enter edge at frame cycle 7.
        clear_counts();
        ciclos = {5'd15, 5'd10, 5'd5};
        enter  = 1'b1;
        tick(1);
        enter = 1'b0;
        tick(7);
        enter = 1'b1;
        tick(1);
        enter = 1'b0;
        tick(40);
        expect_counts("restart", 0, 40, 1, 10, 18, 23);
        expect_counts("restart", 1, 28, 1, 10, 18, 23);

        // Stop while idle does nothing; stop plus enter edge while running goes idle.
        clear_counts();
        stop = 1'b1;
        tick(3);
        stop = 1'b0;
        tick(1);
        chk("idle_stop_busy32_cycles", cb[0], 0);
        chk("idle_stop_busy20_cycles", cb[1], 0);
        clear_counts();
        enter = 1'b1;
        tick(1);
        enter = 1'b0;
        tick(3);
        stop  = 1'b1;
        enter = 1'b1;
        tick(1);
        stop  = 1'b0;
        enter = 1'b0;
        tick(10);
        expect_counts("stop_start", 0, 4, 0, 4, 4, 4);
        expect_counts("stop_start", 1, 4, 0, 4, 4, 4);

        // Asynchronous reset at frame cycle 12 with enter held through release.
        clear_counts();
        enter = 1'b1;
        tick(13);
        #2;
        rst_n = 1'b0;
        #1;
        expect_zero_outputs("async_reset");
        rst_n = 1'b1;
        tick(40);
        enter = 1'b0;
        tick(2);
        expect_counts("reset_mid", 0, 44, 1, 10, 20, 27);
        expect_counts("reset_mid", 1, 32, 1, 10, 20, 27);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
